// File: rtl/hsid_pkg.sv
// Shared constants and types for the HSID spectral-distance blocks.
package hsid_pkg;

  localparam int HSID_DATA_WIDTH      = 16;
  localparam int HSID_DATA_WIDTH_ACC  = 40;
  localparam int HSID_MAX_BANDS       = 128;
  localparam int HSID_MAX_HSP_LIBRARY = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } hsid_sq_df_feeder_state_t;

endpackage

// File: rtl/hsid_skid_buf.sv
// Two-entry valid/ready buffer with pass-through when empty, so an element
// arriving into an empty buffer is presented in the same cycle. The producer
// guarantees it never pushes into a full buffer (it watches occ).
module hsid_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [1:0]   occ,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [1:0]        cnt_q, cnt_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              push, pop;

  assign occ       = cnt_q;
  assign out_valid = (cnt_q != 2'd0) || in_valid;
  assign out_data  = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : in_data;

  // Store incoming data unless it passes straight through; pop on stored transfer.
  always_comb begin
    push     = in_valid && !((cnt_q == 2'd0) && out_ready);
    pop      = (cnt_q != 2'd0) && out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/hsid_sq_df_feeder.sv
// Stream source for hsid_sq_df_acc: reads one pixel spectrum and num_refs
// library spectra and emits band-aligned (a, b) pairs, one reference at a time.
// Optional build macro HSID_SQ_DF_FEEDER_PIX_CACHE_EN: pixel samples are
// cached during reference 0 and the pixel memory is not re-read afterwards.
module hsid_sq_df_feeder
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH     = HSID_DATA_WIDTH,
  parameter int DATA_WIDTH_ACC = HSID_DATA_WIDTH_ACC,
  parameter int MAX_BANDS      = HSID_MAX_BANDS,
  parameter int LIBRARY_SIZE   = HSID_MAX_HSP_LIBRARY,
  localparam int BANDS_ADDR    = $clog2(MAX_BANDS),
  localparam int REF_ADDR      = $clog2(LIBRARY_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BANDS_ADDR:0]       num_bands,
  input  logic [REF_ADDR:0]         num_refs,
  input  logic [DATA_WIDTH_ACC-1:0] init_acc,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      pix_rd_en,
  output logic [BANDS_ADDR-1:0]     pix_rd_addr,
  input  logic [DATA_WIDTH-1:0]     pix_rd_data,
  output logic                      lib_rd_en,
  output logic [REF_ADDR-1:0]       lib_rd_ref,
  output logic [BANDS_ADDR-1:0]     lib_rd_band,
  input  logic [DATA_WIDTH-1:0]     lib_rd_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_a,
  output logic [DATA_WIDTH-1:0]     out_b,
  output logic                      out_last,
  output logic [REF_ADDR-1:0]       out_ref,
  output logic                      out_init_en,
  output logic [DATA_WIDTH_ACC-1:0] out_init_acc
);

  localparam int BW = BANDS_ADDR + 1;
  localparam int RW = REF_ADDR + 1;
  localparam int PW = 2 * DATA_WIDTH + 2 + REF_ADDR;
  localparam logic [BW-1:0] MAX_BANDS_W = BW'(MAX_BANDS);
  localparam logic [BW-1:0] ONE_B       = BW'(1);
  localparam logic [RW-1:0] ONE_R       = RW'(1);

  hsid_sq_df_feeder_state_t state_q, state_d;
  logic [BW-1:0]             nb_q, nb_d, band_q, band_d;
  logic [RW-1:0]             nr_q, nr_d, ref_q, ref_d;
  logic [DATA_WIDTH_ACC-1:0] init_acc_q, init_acc_d;
  logic                      err_q, err_d;
  logic                      infl_q, infl_first_q, infl_last_q;
  logic [REF_ADDR-1:0]       infl_ref_q;

  logic                  issue, band_wrap, last_ref;
  logic [1:0]            occ;
  logic                  buf_vld;
  logic [PW-1:0]         in_pl, head;
  logic [DATA_WIDTH-1:0] in_a;

  assign busy         = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign error        = err_q;
  assign out_init_acc = init_acc_q;

  // A read may go out only if its data is guaranteed a buffer slot on return.
  assign issue     = (state_q == ST_STREAM) && ((occ + {1'b0, infl_q}) < 2'd2);
  assign band_wrap = (band_q == nb_q - ONE_B);
  assign last_ref  = (ref_q == nr_q - ONE_R);

  assign lib_rd_en   = issue;
  assign lib_rd_ref  = issue ? ref_q[REF_ADDR-1:0] : '0;
  assign lib_rd_band = issue ? band_q[BANDS_ADDR-1:0] : '0;
  assign pix_rd_addr = pix_rd_en ? band_q[BANDS_ADDR-1:0] : '0;

`ifdef HSID_SQ_DF_FEEDER_PIX_CACHE_EN
  logic [MAX_BANDS-1:0][DATA_WIDTH-1:0] cache_q, cache_d;
  logic [BANDS_ADDR-1:0]                infl_band_q;

  assign pix_rd_en = issue && (ref_q == '0);
  assign in_a      = (infl_ref_q == '0) ? pix_rd_data : cache_q[infl_band_q];

  // Capture pixel samples as they return during reference 0.
  always_comb begin
    cache_d = cache_q;
    if (infl_q && (infl_ref_q == '0)) cache_d[infl_band_q] = pix_rd_data;
  end

  // Cache storage and band tag of the in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_q     <= '0;
      infl_band_q <= '0;
    end else begin
      cache_q     <= cache_d;
      infl_band_q <= band_q[BANDS_ADDR-1:0];
    end
  end
`else
  assign pix_rd_en = issue;
  assign in_a      = pix_rd_data;
`endif

  // Run control: latch bounds on start, walk (ref, band) as reads issue.
  // Empty or rejected runs pass through DRAIN so done always lands two
  // cycles after the start is sampled.
  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    nr_d       = nr_q;
    band_d     = band_q;
    ref_d      = ref_q;
    init_acc_d = init_acc_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          nb_d       = num_bands;
          nr_d       = num_refs;
          init_acc_d = init_acc;
          band_d     = '0;
          ref_d      = '0;
          err_d      = (num_bands > MAX_BANDS_W);
          if ((num_bands == '0) || (num_refs == '0) || (num_bands > MAX_BANDS_W))
            state_d = ST_DRAIN;
          else
            state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (issue) begin
          if (band_wrap) begin
            band_d = '0;
            ref_d  = ref_q + ONE_R;
            if (last_ref) state_d = ST_DRAIN;
          end else begin
            band_d = band_q + ONE_B;
          end
        end
      end
      ST_DRAIN: if (!infl_q && (occ == 2'd0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control and in-flight tag registers; reset drops any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      nb_q         <= '0;
      nr_q         <= '0;
      band_q       <= '0;
      ref_q        <= '0;
      init_acc_q   <= '0;
      err_q        <= 1'b0;
      infl_q       <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      infl_ref_q   <= '0;
    end else begin
      state_q      <= state_d;
      nb_q         <= nb_d;
      nr_q         <= nr_d;
      band_q       <= band_d;
      ref_q        <= ref_d;
      init_acc_q   <= init_acc_d;
      err_q        <= err_d;
      infl_q       <= issue;
      infl_first_q <= (band_q == '0);
      infl_last_q  <= band_wrap;
      infl_ref_q   <= ref_q[REF_ADDR-1:0];
    end
  end

  assign in_pl = {in_a, lib_rd_data, infl_first_q, infl_last_q, infl_ref_q};

  hsid_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (infl_q),
    .in_data   (in_pl),
    .occ       (occ),
    .out_ready (out_ready),
    .out_valid (buf_vld),
    .out_data  (head)
  );

  // Head fields are forced to zero when nothing is valid.
  assign out_valid   = buf_vld;
  assign out_ref     = buf_vld ? head[REF_ADDR-1:0] : '0;
  assign out_last    = buf_vld && head[REF_ADDR];
  assign out_init_en = buf_vld && head[REF_ADDR+1];
  assign out_b       = buf_vld ? head[REF_ADDR+2 +: DATA_WIDTH] : '0;
  assign out_a       = buf_vld ? head[REF_ADDR+2+DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: doc/hsid_sq_df_feeder.md
# hsid_sq_df_feeder

Stream source for `hsid_sq_df_acc`. On `start`, reads one pixel spectrum and `num_refs` library spectra from two synchronous read memories. Emits band-aligned `(a, b)` pairs in the accumulator's input protocol: valid/last/ref plus an initial-accumulator strobe. One full spectrum is emitted per reference, references in ascending order.

## Interface
- `DATA_WIDTH`, `HSID_DATA_WIDTH` (16): sample width.
- `DATA_WIDTH_ACC`, `HSID_DATA_WIDTH_ACC`: initial-accumulator width.
- `MAX_BANDS`, `HSID_MAX_BANDS` (128): max bands; `BANDS_ADDR = $clog2(MAX_BANDS)`.
- `LIBRARY_SIZE`, `HSID_MAX_HSP_LIBRARY`: max references; `REF_ADDR = $clog2(LIBRARY_SIZE)`.
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: asynchronous, active-high reset.
- Control:
  - `start` in 1: launch a run; sampled only in IDLE.
  - `num_bands` in BANDS_ADDR+1: bands per spectrum; latched at start.
  - `num_refs` in REF_ADDR+1: references to stream; latched at start.
  - `init_acc` in DATA_WIDTH_ACC: initial accumulator value; latched at start.
  - `busy` out 1: high from the cycle after accepted start until done.
  - `done` out 1: one-cycle pulse at end of run.
  - `error` out 1: sticky until next accepted start; set when `num_bands > MAX_BANDS`.
- Pixel memory:
  - `pix_rd_en` out 1: pixel memory read enable.
  - `pix_rd_addr` out BANDS_ADDR: pixel memory read address.
  - `pix_rd_data` in DATA_WIDTH: read data, 1-cycle latency.
- Library memory:
  - `lib_rd_en` out 1: library memory read enable.
  - `lib_rd_ref` out REF_ADDR: library reference address.
  - `lib_rd_band` out BANDS_ADDR: library band address.
  - `lib_rd_data` in DATA_WIDTH: read data, 1-cycle latency.
- Output stream:
  - `out_ready` in 1: downstream accept; tie high when driving the accumulator directly.
  - `out_valid` out 1: element valid.
  - `out_a` out DATA_WIDTH: pixel sample.
  - `out_b` out DATA_WIDTH: library sample.
  - `out_last` out 1: last band of the current reference.
  - `out_ref` out REF_ADDR: current reference index.
  - `out_init_en` out 1: start of a new reference.
  - `out_init_acc` out DATA_WIDTH_ACC: initial accumulator value.

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - `start` with `num_bands==0` or `num_refs==0` -> DONE, no output elements.
  - `num_bands>MAX_BANDS` -> set `error`, DONE.
  - Otherwise latch inputs, clear band/ref counters -> STREAM.
- STREAM:
  - Each cycle with a free slot, issue one read pair at `(ref, band)`, then advance band.
  - On wrap `band==num_bands-1`: band=0, ref++.
  - After issuing `(num_refs-1, num_bands-1)` -> DRAIN.
- DRAIN: wait until in-flight reads are empty and the output buffer is empty -> DONE.
- DONE: pulse `done`, deassert `busy` -> IDLE.
- Each read carries a tag `{first, last, ref}` through the 1-cycle memory latency alongside its data.
- Output buffer:
  - 2-entry skid buffer.
  - Issue condition: occupancy + in-flight < 2.
  - Output fields come from the head entry.
- Per element: `out_init_en = first` (band 0); `out_init_acc` = latched `init_acc`, constant for the run.
- Pure data movement, no arithmetic. Counters are unsigned and compared against the latched bounds only.
- `start` while busy: ignored.
- Reset mid-run:
  - All state cleared immediately and the FSM returns to IDLE.
  - The in-flight read is discarded.
  - No `done` pulse.

## Timing
- Reset values: every output 0; FSM in IDLE.
- Accepted start sampled at cycle 0:
  - `busy` high from cycle 1.
  - First reads issued at cycle 1.
  - First `out_valid` at cycle 2.
- With `out_ready` held high, throughput is one element per cycle, no gaps between references.
  - Last element at cycle `num_refs*num_bands+1`.
  - `done` two cycles after that element is accepted.
- Handshake:
  - An element transfers when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, all output fields stay stable.
  - `out_valid` never drops without a transfer.
- `out_ready` low for N cycles with a full buffer:
  - No reads are issued.
  - Streaming resumes the cycle after `out_ready` rises, with no loss or duplication.

## Configuration
- Macro: `HSID_SQ_DF_FEEDER_PIX_CACHE_EN`.
- With the macro defined:
  - Pixel samples are written into an internal MAX_BANDS×DATA_WIDTH register cache during reference 0.
  - References ≥1 read `out_a` from the cache.
  - `pix_rd_en` is active only during reference 0, for exactly `num_bands` reads.
- Without the macro: the pixel memory is re-read for every reference (`num_refs*num_bands` reads).
- Output stream is identical cycle-for-cycle in both builds.

## Structure
- `hsid_pkg`: add `HSID_MAX_BANDS` and the typedef `hsid_sq_df_feeder_state_t` (enum of the four states).
- Sub-module `hsid_skid_buf`: a 2-entry valid/ready buffer, parameterized on payload width; the payload is `{a, b, first, last, ref}`.

## Test plan
- Nominal: `num_bands=4`, `num_refs=3`, `init_acc=7`, `out_ready=1`:
  - 12 elements on cycles 2–13.
  - `out_init_en` at bands 0; `out_last` at bands 3.
  - `out_ref` sequence 0,0,0,0,1,…,2.
  - `done` at cycle 15.
- Backpressure: same run with `out_ready` random 50% -> identical element sequence, fields stable during stalls, no drops or duplicates.
- Accumulator loopback: drive `hsid_sq_df_acc` with random vectors -> each `acc_value` on `acc_last` equals `init_acc + Σ(a-b)²`, and `acc_ref` matches.
- Degenerate: `num_refs=0` -> `done` at cycle 2, no `out_valid`. `num_bands=MAX_BANDS+1` -> `error=1`, no output.
- Reset mid-run: assert `rst` at element 5 -> all outputs 0 next edge. A new start after release produces a clean full run.
- `PIX_CACHE_EN` build: `num_refs=3` -> `pix_rd_en` count equals `num_bands`, and the output stream matches the non-cache build.
